// File: rtl/result_collector_pkg.sv
// Shared types and sizing helpers for the result collector slice.
package result_collector_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      FLUSH
   } rc_state_e;

   localparam int SEQW = 8;

   // The result grows by log2 of the operand count over the operand width.
   function automatic int rc_rw(input int bits, input int cges);
      return $clog2(cges) + bits;
   endfunction

endpackage

// File: rtl/result_collector_if.sv
// Capture inputs and valid/ready result stream of the collector; optional out_seq under RESULT_COLLECTOR_SEQ_EN.
interface result_collector_if
   import result_collector_pkg::*;
#(
   parameter int BITS  = 32,
   parameter int CGES  = 13,
   parameter int DEPTH = 8
) ();

   localparam int RW = rc_rw(BITS, CGES);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            cal;
   logic [RW-1:0]   result;
   logic [RW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic [CW-1:0]   count;
   logic            overflow;
   logic            clr_ovf;
`ifdef RESULT_COLLECTOR_SEQ_EN
   logic [SEQW-1:0] out_seq;
`endif

   modport master (
`ifdef RESULT_COLLECTOR_SEQ_EN
      input  out_seq,
`endif
      output cal,
      output result,
      output out_ready,
      output clr_ovf,
      input  out_data,
      input  out_valid,
      input  out_last,
      input  count,
      input  overflow
   );

   modport slave (
`ifdef RESULT_COLLECTOR_SEQ_EN
      output out_seq,
`endif
      input  cal,
      input  result,
      input  out_ready,
      input  clr_ovf,
      output out_data,
      output out_valid,
      output out_last,
      output count,
      output overflow
   );

endinterface

// File: rtl/result_collector_fifo.sv
// FWFT FIFO: a push at edge t is visible on o_dout after edge t; pushes while full are refused unless popped the same cycle.
// i_mark ORs i_mark_mask into the newest stored entry so a caller can retag it without writing.
module rc_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_push,
   input  logic [W-1:0]  i_din,
   input  logic          i_pop,
   input  logic          i_mark,
   input  logic [W-1:0]  i_mark_mask,
   output logic [W-1:0]  o_dout,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [AW-1:0] w_newest;
   logic          w_wr;
   logic          w_rd;

   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_wr     = i_push & (~o_full | i_pop);
   assign w_rd     = i_pop & ~o_empty;
   assign w_newest = r_wr_ptr - AW'(1);
   assign o_dout   = r_mem[r_rd_ptr];
   assign o_count  = r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end else if (i_mark && !o_empty) begin
            r_mem[w_newest] <= r_mem[w_newest] | i_mark_mask;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/result_collector.sv
// Captures `result` the cycle after `cal` into a FWFT FIFO (one cycle storage latency) and streams it out valid/ready;
// when full and not popped a sample is dropped and `overflow` set. RESULT_COLLECTOR_SEQ_EN adds per-window out_seq.
module result_collector
   import result_collector_pkg::*;
#(
   parameter int BITS  = 32,
   parameter int CGES  = 13,
   parameter int DEPTH = 8
) (
   input logic                clk,
   input logic                reset_n,
   result_collector_if.slave  bus
);

   localparam int RW = rc_rw(BITS, CGES);
   localparam int CW = $clog2(DEPTH) + 1;
`ifdef RESULT_COLLECTOR_SEQ_EN
   localparam int EW = SEQW + 1 + RW;
`else
   localparam int EW = 1 + RW;
`endif
   localparam logic [EW-1:0] LAST_MASK = EW'(1) << RW;

   rc_state_e      r_state;
   rc_state_e      w_next;
   logic           r_cal_d;
   logic           r_ovf;
   logic           w_push;
   logic           w_last;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic           w_drop;
   logic           w_mark;
   logic [EW-1:0]  w_din;
   logic [EW-1:0]  w_dout;
   logic [CW-1:0]  w_count;
`ifdef RESULT_COLLECTOR_SEQ_EN
   logic [SEQW-1:0] r_seq;
`endif

   assign w_push = r_cal_d;
   assign w_last = r_cal_d & ~bus.cal;
   assign w_pop  = ~w_empty & bus.out_ready;
   assign w_drop = w_push & w_full & ~w_pop;
   // A dropped window end still closes the window on whatever made it in.
   assign w_mark = w_drop & w_last;

`ifdef RESULT_COLLECTOR_SEQ_EN
   assign w_din = {r_seq, w_last, bus.result};
`else
   assign w_din = {w_last, bus.result};
`endif

   rc_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_push),
      .i_din       (w_din),
      .i_pop       (w_pop),
      .i_mark      (w_mark),
      .i_mark_mask (LAST_MASK),
      .o_dout      (w_dout),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign bus.out_data  = w_dout[RW-1:0];
   assign bus.out_last  = w_dout[RW];
   assign bus.out_valid = ~w_empty;
   assign bus.count     = w_count;
   assign bus.overflow  = r_ovf;
`ifdef RESULT_COLLECTOR_SEQ_EN
   assign bus.out_seq   = w_dout[EW-1 -: SEQW];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cal_d <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cal_d <= bus.cal;
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
         end
      end
   end

`ifdef RESULT_COLLECTOR_SEQ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seq <= '0;
      end else if (w_push && w_last) begin
         r_seq <= r_seq + SEQW'(1);
      end
   end
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.cal) w_next = CAPTURE;
         end
         CAPTURE: begin
            if (w_push && w_last) w_next = FLUSH;
         end
         FLUSH: begin
            // A new burst while draining is queued behind the current window.
            if (bus.cal)      w_next = CAPTURE;
            else if (w_empty) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: burst capture, overflow framing, full-with-pop, back-to-back windows and reset.
module tb_result_collector;
   import result_collector_pkg::*;

   localparam int BITS  = 32;
   localparam int CGES  = 13;
   localparam int DEPTH = 8;
   localparam int RW    = rc_rw(BITS, CGES);

   logic clk;
   logic reset_n;
   int   vectors;
   int   miscompares;
   logic [RW:0] q[$];
`ifdef RESULT_COLLECTOR_SEQ_EN
   logic [SEQW-1:0] qs[$];
`endif

   result_collector_if #(.BITS(BITS), .CGES(CGES), .DEPTH(DEPTH)) bus ();

   result_collector #(.BITS(BITS), .CGES(CGES), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record each beat that will be accepted at the next rising edge.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         q.push_back({bus.out_last, bus.out_data});
`ifdef RESULT_COLLECTOR_SEQ_EN
         qs.push_back(bus.out_seq);
`endif
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic l, input logic [RW-1:0] d);
      logic [RW:0] got;
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: observed no beat expected %0h", tag, {l, d});
      end else begin
         got = q.pop_front();
         chk(tag, 64'(got), 64'({l, d}));
      end
   endtask

   task automatic cyc(input logic c, input logic [RW-1:0] r, input logic rdy, input logic clr);
      bus.cal       = c;
      bus.result    = r;
      bus.out_ready = rdy;
      bus.clr_ovf   = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n       = 1'b0;
      bus.cal       = 1'b0;
      bus.result    = '0;
      bus.out_ready = 1'b0;
      bus.clr_ovf   = 1'b0;
      #12;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);
      chk("rst_data", 64'(bus.out_data), 64'd0);
      chk("rst_last", 64'(bus.out_last), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Three-sample window, streamed straight out.
      cyc(1'b1, 36'd0, 1'b1, 1'b0);
      cyc(1'b1, 36'd10, 1'b1, 1'b0);
      cyc(1'b1, 36'd20, 1'b1, 1'b0);
      cyc(1'b0, 36'd30, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 36'd0, 1'b1, 1'b0);
      pop_chk("w1_b0", 1'b0, 36'd10);
      pop_chk("w1_b1", 1'b0, 36'd20);
      pop_chk("w1_b2", 1'b1, 36'd30);
      chk("w1_qempty", 64'(q.size()), 64'd0);
      chk("w1_count", 64'(bus.count), 64'd0);
      chk("w1_state", 64'(dut.r_state), 64'(IDLE));

      // Single-cycle pulse with an all-ones result.
      cyc(1'b1, 36'd0, 1'b1, 1'b0);
      cyc(1'b0, 36'hF_FFFF_FFFF, 1'b1, 1'b0);
      chk("p_valid", 64'(bus.out_valid), 64'd1);
      chk("p_data", 64'(bus.out_data), 64'hF_FFFF_FFFF);
      chk("p_last", 64'(bus.out_last), 64'd1);
      for (int i = 0; i < 2; i++) cyc(1'b0, 36'd0, 1'b1, 1'b0);
      pop_chk("p_beat", 1'b1, 36'hF_FFFF_FFFF);
      chk("p_qempty", 64'(q.size()), 64'd0);

      // Overflow: ten samples into eight entries, the last drop meets clr_ovf.
      cyc(1'b1, 36'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++) cyc(1'b1, 36'(i), 1'b0, 1'b0);
      cyc(1'b0, 36'd10, 1'b0, 1'b1);
      chk("ov_count", 64'(bus.count), 64'd8);
      chk("ov_flag_setwins", 64'(bus.overflow), 64'd1);
      chk("ov_head", 64'(bus.out_data), 64'd1);
      chk("ov_head_last", 64'(bus.out_last), 64'd0);
      cyc(1'b0, 36'd0, 1'b0, 1'b0);
      chk("ov_stable", 64'(bus.out_data), 64'd1);
      for (int i = 0; i < 9; i++) cyc(1'b0, 36'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) pop_chk("ov_drain", (i == 8), 36'(i));
      chk("ov_qempty", 64'(q.size()), 64'd0);
      chk("ov_held", 64'(bus.overflow), 64'd1);
      cyc(1'b0, 36'd0, 1'b0, 1'b1);
      chk("ov_cleared", 64'(bus.overflow), 64'd0);

      // Full with a simultaneous pop: push accepted, occupancy unchanged.
      cyc(1'b1, 36'd0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 36'(101 + i), 1'b0, 1'b0);
      chk("fp_full", 64'(bus.count), 64'd8);
      cyc(1'b0, 36'd109, 1'b1, 1'b0);
      chk("fp_count", 64'(bus.count), 64'd8);
      chk("fp_ovf", 64'(bus.overflow), 64'd0);
      chk("fp_head", 64'(bus.out_data), 64'd102);
      for (int i = 0; i < 10; i++) cyc(1'b0, 36'd0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) pop_chk("fp_drain", (i == 8), 36'(101 + i));
      chk("fp_qempty", 64'(q.size()), 64'd0);

      // Reset in the middle of a capture with five entries held.
      cyc(1'b1, 36'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) cyc(1'b1, 36'(i), 1'b0, 1'b0);
      chk("mr_count_pre", 64'(bus.count), 64'd5);
      reset_n = 1'b0;
      #2;
      chk("mr_valid", 64'(bus.out_valid), 64'd0);
      chk("mr_count", 64'(bus.count), 64'd0);
      chk("mr_ovf", 64'(bus.overflow), 64'd0);
      bus.cal = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) cyc(1'b0, 36'd0, 1'b0, 1'b0);
      chk("mr_state", 64'(dut.r_state), 64'(IDLE));
      chk("mr_valid_post", 64'(bus.out_valid), 64'd0);

      // Second window starts while the first is still draining.
      cyc(1'b1, 36'd0, 1'b0, 1'b0);
      cyc(1'b1, 36'h11, 1'b0, 1'b0);
      cyc(1'b0, 36'h12, 1'b0, 1'b0);
      chk("bb_count", 64'(bus.count), 64'd2);
      chk("bb_flush", 64'(dut.r_state), 64'(FLUSH));
      cyc(1'b1, 36'd0, 1'b1, 1'b0);
      chk("bb_recapture", 64'(dut.r_state), 64'(CAPTURE));
      cyc(1'b1, 36'h21, 1'b1, 1'b0);
      cyc(1'b0, 36'h22, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 36'd0, 1'b1, 1'b0);
`ifdef RESULT_COLLECTOR_SEQ_EN
      if (qs.size() == 4) begin
         chk("bb_seq0", 64'(qs[0]), 64'd0);
         chk("bb_seq1", 64'(qs[1]), 64'd0);
         chk("bb_seq2", 64'(qs[2]), 64'd1);
         chk("bb_seq3", 64'(qs[3]), 64'd1);
      end else begin
         chk("bb_seq_beats", 64'(qs.size()), 64'd4);
      end
`endif
      pop_chk("bb_b0", 1'b0, 36'h11);
      pop_chk("bb_b1", 1'b1, 36'h12);
      pop_chk("bb_b2", 1'b0, 36'h21);
      pop_chk("bb_b3", 1'b1, 36'h22);
      chk("bb_qempty", 64'(q.size()), 64'd0);
      chk("bb_count_end", 64'(bus.count), 64'd0);
      chk("bb_idle", 64'(dut.r_state), 64'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
